chanlink_evt_writer: RTL and testbench

- Upstream feeder of the channel-link readout FIFO stage, in the WCLK domain.
- Maintains the ADC sample ring write pointer and queues a window start address for each matched L1A.
- Reads each window back out of the ring as 18-bit words (sample-major, NCHAN channels per sample) into the event buffer.
- Writes one 37-bit L1A record per accepted event, and tags words with overlap information.

---
 rtl/chanlink_pkg.sv | 22 ++
 rtl/evt_start_queue.sv | 65 ++++++
 rtl/chanlink_evt_writer.sv | 204 ++++++++++++++++++++
 tb/tb_chanlink_evt_writer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chanlink_pkg.sv
// Shared types and field layout for the channel-link event writer:
// reader FSM states, word/record field offsets and ring read latency.
package chanlink_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} wr_state_t;

  localparam int WD_ADC_LSB   = 0;
  localparam int WD_OCNT_LSB  = 12;
  localparam int WD_OVRLP_BIT = 16;
  localparam int WD_MOVLP_BIT = 17;

  localparam int EVT_L1A_LSB   = 0;
  localparam int EVT_MATCH_LSB = 24;
  localparam int EVT_PHASE_BIT = 36;

  localparam int RD_LAT = 2;

  function automatic logic [3:0] sat_ocnt(input int n);
    return (n > 15) ? 4'd15 : n[3:0];
  endfunction

endpackage

// File: rtl/evt_start_queue.sv
// Small FIFO of pending readout windows {start, ocnt, ovrlp, movlp}; also
// exposes every slot's start address and occupancy for overlap counting.
module evt_start_queue #(
  parameter int AW    = 9,
  parameter int QLOG2 = 3,
  parameter int EW    = AW + 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [EW-1:0]             wr_data,
  output logic [EW-1:0]             rd_data,
  output logic [QLOG2:0]            count,
  output logic                      full,
  output logic                      empty,
  output logic [(2**QLOG2)*AW-1:0]  slot_start,
  output logic [(2**QLOG2)-1:0]     slot_valid
);

  localparam int DEPTH = 2**QLOG2;

  logic [EW-1:0]    mem [DEPTH];
  logic [QLOG2-1:0] rd_ptr;
  logic [QLOG2-1:0] wr_ptr;
  logic [QLOG2-1:0] rel;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (QLOG2+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // A slot is occupied when its distance past the read pointer is below count
  always_comb begin
    slot_start = '0;
    slot_valid = '0;
    rel        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_start[i*AW +: AW] = mem[i][EW-1 -: AW];
      rel                    = QLOG2'(i) - rd_ptr;
      slot_valid[i]          = ({1'b0, rel} < count);
    end
  end

endmodule

// File: rtl/chanlink_evt_writer.sv
// Ring write pointer, L1A bookkeeping and window readout into the event buffer:
// each matched L1A queues a window that is read back sample-major, NCHAN words per sample.
module chanlink_evt_writer
  import chanlink_pkg::*;
#(
  parameter int NCHAN      = 6,
  parameter int AW         = 9,
  parameter int PIPE_DEPTH = 100,
  parameter int QLOG2      = 3
) (
  input  logic                WCLK,
  input  logic                RST_RESYNC,
  input  logic                SAMP_CE,
  input  logic                L1A,
  input  logic                L1A_MATCH,
  input  logic                L1A_PHASE,
  input  logic [6:0]          SAMP_MAX,
  input  logic                EVT_BUF_AFL,
  output logic                RING_WE,
  output logic [AW-1:0]       RING_WADDR,
  output logic [AW-1:0]       RING_RADDR,
  input  logic [12*NCHAN-1:0] RING_RDATA,
  output logic [17:0]         WDATA,
  output logic                WREN,
  output logic [36:0]         L1A_EVT_DATA,
  output logic                L1A_WRT_EN,
  output logic                BUSY,
  output logic                QOVF
);

  localparam int DEPTH = 2**QLOG2;
  localparam int EW    = AW + 6;
  localparam int CW    = $clog2(NCHAN);

  logic [EW-1:0]       q_head;
  logic [EW-1:0]       q_wr;
  logic [QLOG2:0]      q_count;
  logic                q_full;
  logic                q_empty;
  logic [DEPTH*AW-1:0] slot_start;
  logic [DEPTH-1:0]    slot_valid;
  logic                push;
  logic                pop;

  logic [AW-1:0] new_start;
  int            ocnt_sum;
  logic [3:0]    new_ocnt;

  wr_state_t     state;
  logic [AW-1:0] cur_start;
  logic [5:0]    cur_flags;
  logic [6:0]    samp_off;
  logic [CW-1:0] chan;
  logic [1:0]    drain;

  logic          iss_v;
  logic [CW-1:0] iss_chan;
  logic [5:0]    iss_flags;
  logic [RD_LAT-1:0] p_v;
  logic [CW-1:0]     p_chan  [RD_LAT];
  logic [5:0]        p_flags [RD_LAT];

  logic [23:0] l1a_cnt;
  logic [11:0] match_cnt;

  assign RING_WE   = SAMP_CE;
  assign BUSY      = (state != IDLE) || (q_count != '0);
  assign new_start = RING_WADDR - AW'(PIPE_DEPTH);
  assign push      = L1A_MATCH && !q_full;
  // A window only starts when the event buffer has room, so a full backlog stays queued
  assign pop       = (state == IDLE) && !q_empty && !EVT_BUF_AFL;
  assign q_wr      = {new_start, new_ocnt, (new_ocnt != 4'd0), (new_ocnt >= 4'd2)};

  // Prior windows (queued or being read) starting at most SAMP_MAX samples earlier overlap
  always_comb begin
    ocnt_sum = 0;
    for (int i = 0; i < DEPTH; i++)
      if (slot_valid[i] && ((new_start - slot_start[i*AW +: AW]) <= AW'(SAMP_MAX)))
        ocnt_sum = ocnt_sum + 1;
    if ((state != IDLE) && ((new_start - cur_start) <= AW'(SAMP_MAX)))
      ocnt_sum = ocnt_sum + 1;
    new_ocnt = sat_ocnt(ocnt_sum);
  end

  evt_start_queue #(.AW(AW), .QLOG2(QLOG2), .EW(EW)) u_queue (
    .clk        (WCLK),
    .rst        (RST_RESYNC),
    .push       (push),
    .pop        (pop),
    .wr_data    (q_wr),
    .rd_data    (q_head),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty),
    .slot_start (slot_start),
    .slot_valid (slot_valid)
  );

  always_ff @(posedge WCLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      RING_WADDR   <= '0;
      l1a_cnt      <= '0;
      match_cnt    <= '0;
      L1A_WRT_EN   <= 1'b0;
      L1A_EVT_DATA <= '0;
      QOVF         <= 1'b0;
    end else begin
      if (SAMP_CE)   RING_WADDR <= RING_WADDR + 1'b1;
      if (L1A)       l1a_cnt    <= l1a_cnt + 24'd1;
      if (L1A_MATCH) match_cnt  <= match_cnt + 12'd1;
      L1A_WRT_EN <= push;
      if (push) begin
        L1A_EVT_DATA[EVT_PHASE_BIT]       <= L1A_PHASE;
        L1A_EVT_DATA[EVT_MATCH_LSB +: 12] <= match_cnt + 12'd1;
        L1A_EVT_DATA[EVT_L1A_LSB +: 24]   <= L1A ? l1a_cnt + 24'd1 : l1a_cnt;
      end
      if (L1A_MATCH && q_full) QOVF <= 1'b1;
    end
  end

  always_ff @(posedge WCLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      state      <= IDLE;
      cur_start  <= '0;
      cur_flags  <= '0;
      samp_off   <= '0;
      chan       <= '0;
      drain      <= '0;
      iss_v      <= 1'b0;
      iss_chan   <= '0;
      iss_flags  <= '0;
      RING_RADDR <= '0;
    end else begin
      case (state)
        IDLE: begin
          iss_v <= 1'b0;
          if (pop) begin
            cur_start <= q_head[EW-1 -: AW];
            cur_flags <= {q_head[0], q_head[1], q_head[5:2]};
            samp_off  <= '0;
            chan      <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (!EVT_BUF_AFL) begin
            iss_v      <= 1'b1;
            RING_RADDR <= cur_start + AW'(samp_off);
            iss_chan   <= chan;
            iss_flags  <= cur_flags;
            if (chan == CW'(NCHAN-1)) begin
              chan <= '0;
              if (samp_off == SAMP_MAX) begin
                state <= DONE;
                drain <= '0;
              end else begin
                samp_off <= samp_off + 7'd1;
              end
            end else begin
              chan <= chan + 1'b1;
            end
          end else begin
            iss_v <= 1'b0;
          end
        end
        DONE: begin
          iss_v <= 1'b0;
          if (drain == 2'd2) state <= IDLE;
          else               drain <= drain + 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channel and flags travel alongside the read so they line up with RING_RDATA
  always_ff @(posedge WCLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      p_v   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        p_chan[i]  <= '0;
        p_flags[i] <= '0;
      end
      WREN  <= 1'b0;
      WDATA <= '0;
    end else begin
      p_v        <= {p_v[RD_LAT-2:0], iss_v};
      p_chan[0]  <= iss_chan;
      p_flags[0] <= iss_flags;
      for (int i = 1; i < RD_LAT; i++) begin
        p_chan[i]  <= p_chan[i-1];
        p_flags[i] <= p_flags[i-1];
      end
      WREN <= p_v[RD_LAT-1];
      if (p_v[RD_LAT-1]) begin
        WDATA[WD_ADC_LSB +: 12] <= RING_RDATA[12*p_chan[RD_LAT-1] +: 12];
        WDATA[WD_OCNT_LSB +: 4] <= p_flags[RD_LAT-1][3:0];
        WDATA[WD_OVRLP_BIT]     <= p_flags[RD_LAT-1][4];
        WDATA[WD_MOVLP_BIT]     <= p_flags[RD_LAT-1][5];
      end
    end
  end

endmodule

// File: tb/tb_chanlink_evt_writer.sv
// Directed bench for chanlink_evt_writer; the ring model returns {addr, chan} per channel
// so every word identifies the sample address and channel it came from.
module tb_chanlink_evt_writer;

  localparam int NCHAN = 6;
  localparam int AW    = 9;

  logic                WCLK = 1'b0;
  logic                RST_RESYNC;
  logic                SAMP_CE;
  logic                L1A;
  logic                L1A_MATCH;
  logic                L1A_PHASE;
  logic [6:0]          SAMP_MAX;
  logic                EVT_BUF_AFL;
  logic                RING_WE;
  logic [AW-1:0]       RING_WADDR;
  logic [AW-1:0]       RING_RADDR;
  logic [12*NCHAN-1:0] RING_RDATA;
  logic [17:0]         WDATA;
  logic                WREN;
  logic [36:0]         L1A_EVT_DATA;
  logic                L1A_WRT_EN;
  logic                BUSY;
  logic                QOVF;

  always #5 WCLK = ~WCLK;

  chanlink_evt_writer dut (
    .WCLK         (WCLK),
    .RST_RESYNC   (RST_RESYNC),
    .SAMP_CE      (SAMP_CE),
    .L1A          (L1A),
    .L1A_MATCH    (L1A_MATCH),
    .L1A_PHASE    (L1A_PHASE),
    .SAMP_MAX     (SAMP_MAX),
    .EVT_BUF_AFL  (EVT_BUF_AFL),
    .RING_WE      (RING_WE),
    .RING_WADDR   (RING_WADDR),
    .RING_RADDR   (RING_RADDR),
    .RING_RDATA   (RING_RDATA),
    .WDATA        (WDATA),
    .WREN         (WREN),
    .L1A_EVT_DATA (L1A_EVT_DATA),
    .L1A_WRT_EN   (L1A_WRT_EN),
    .BUSY         (BUSY),
    .QOVF         (QOVF)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [17:0] obs_w[$];
  int          obs_wc[$];
  logic [36:0] obs_e[$];
  int          obs_ec[$];

  always @(posedge WCLK) cyc <= cyc + 1;

  function automatic logic [71:0] ring_row(input logic [8:0] a);
    logic [71:0] r;
    r = '0;
    for (int c = 0; c < NCHAN; c++) r[12*c +: 12] = {a, 3'(c)};
    return r;
  endfunction

  // Ring memory with two-cycle read latency
  logic [AW-1:0] rd_stage;
  always @(posedge WCLK) begin
    rd_stage   <= RING_RADDR;
    RING_RDATA <= ring_row(rd_stage);
  end

  always @(negedge WCLK) begin
    if (WREN) begin
      obs_w.push_back(WDATA);
      obs_wc.push_back(cyc);
    end
    if (L1A_WRT_EN) begin
      obs_e.push_back(L1A_EVT_DATA);
      obs_ec.push_back(cyc);
    end
  end

  function automatic logic [17:0] exp_word(input logic [8:0] s, input int k, input logic [3:0] oc);
    logic [8:0] a;
    logic [2:0] ch;
    a  = s + 9'(k / NCHAN);
    ch = 3'(k % NCHAN);
    return {(oc >= 4'd2), (oc != 4'd0), oc, a, ch};
  endfunction

  function automatic int first_diff(input int base, input int n, input logic [8:0] s, input logic [3:0] oc);
    for (int k = 0; k < n; k++) begin
      if (base + k >= obs_w.size()) return k;
      if (obs_w[base+k] !== exp_word(s, k, oc)) return k;
    end
    return -1;
  endfunction

  function automatic logic [17:0] got_at(input int i);
    if (i >= 0 && i < obs_w.size()) return obs_w[i];
    return 'x;
  endfunction

  task automatic clear_obs();
    obs_w.delete();
    obs_wc.delete();
    obs_e.delete();
    obs_ec.delete();
  endtask

  task automatic do_reset();
    RST_RESYNC  = 1'b1;
    SAMP_CE     = 1'b0;
    L1A         = 1'b0;
    L1A_MATCH   = 1'b0;
    L1A_PHASE   = 1'b0;
    EVT_BUF_AFL = 1'b0;
    repeat (3) @(posedge WCLK);
    #1;
    RST_RESYNC = 1'b0;
    @(posedge WCLK);
    #1;
    clear_obs();
  endtask

  task automatic samp_pulses(input int n, input int gap);
    repeat (n) begin
      SAMP_CE = 1'b1;
      @(posedge WCLK);
      #1;
      SAMP_CE = 1'b0;
      for (int g = 1; g < gap; g++) begin
        @(posedge WCLK);
        #1;
      end
    end
  endtask

  task automatic fire_match(input logic ph, output int mcyc);
    L1A       = 1'b1;
    L1A_MATCH = 1'b1;
    L1A_PHASE = ph;
    mcyc      = cyc;
    @(posedge WCLK);
    #1;
    L1A       = 1'b0;
    L1A_MATCH = 1'b0;
    L1A_PHASE = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obs_w.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge WCLK);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [77:0] outs;
    RST_RESYNC  = 1'b1;
    SAMP_CE     = 1'b0;
    L1A         = 1'b0;
    L1A_MATCH   = 1'b0;
    L1A_PHASE   = 1'b0;
    EVT_BUF_AFL = 1'b0;
    SAMP_MAX    = 7'd15;
    repeat (2) @(posedge WCLK);
    #1;
    outs = {RING_WE, RING_WADDR, RING_RADDR, WDATA, WREN, L1A_EVT_DATA, L1A_WRT_EN, BUSY, QOVF};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%h want=0", outs);
    end
  endtask

  task automatic test_single();
    int m, fd;
    bit ok;
    do_reset();
    SAMP_MAX = 7'd15;
    SAMP_CE  = 1'b1;
    #1;
    total++;
    if (RING_WE !== 1'b1) begin bad++; $display("[TB] FAIL ring_we got=%b want=1", RING_WE); end
    SAMP_CE = 1'b0;
    #1;
    samp_pulses(150, 8);
    total++;
    if (RING_WADDR !== 9'd150) begin bad++; $display("[TB] FAIL single_waddr got=%0d want=150", RING_WADDR); end
    fire_match(1'b0, m);
    wait_words(96, 400, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL single_timeout got=%0d want=96", obs_w.size()); end
    repeat (20) @(posedge WCLK);
    #1;
    total++;
    if (obs_w.size() != 96) begin bad++; $display("[TB] FAIL single_count got=%0d want=96", obs_w.size()); end
    fd = first_diff(0, 96, 9'd50, 4'd0);
    total++;
    if (fd != -1) begin bad++; $display("[TB] FAIL single_words idx=%0d got=%h want=%h", fd, got_at(fd), exp_word(9'd50, fd, 4'd0)); end
    total++;
    if (obs_e.size() != 1) begin bad++; $display("[TB] FAIL single_evt_count got=%0d want=1", obs_e.size()); end
    else begin
      total++;
      if (obs_e[0] !== {1'b0, 12'd1, 24'd1}) begin bad++; $display("[TB] FAIL single_evt_data got=%h want=%h", obs_e[0], {1'b0, 12'd1, 24'd1}); end
      total++;
      if (obs_ec[0] != m + 1) begin bad++; $display("[TB] FAIL single_evt_cycle got=%0d want=%0d", obs_ec[0], m + 1); end
    end
    total++;
    if (BUSY !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_end got=%b want=0", BUSY); end
  endtask

  task automatic test_overlap2();
    int m, fd;
    bit ok;
    do_reset();
    SAMP_MAX = 7'd15;
    samp_pulses(120, 1);
    fire_match(1'b0, m);
    samp_pulses(10, 2);
    fire_match(1'b1, m);
    wait_words(192, 800, ok);
    repeat (20) @(posedge WCLK);
    #1;
    total++;
    if (obs_w.size() != 192) begin bad++; $display("[TB] FAIL ovl2_count got=%0d want=192", obs_w.size()); end
    fd = first_diff(0, 96, 9'd20, 4'd0);
    total++;
    if (fd != -1) begin bad++; $display("[TB] FAIL ovl2_ev0 idx=%0d got=%h want=%h", fd, got_at(fd), exp_word(9'd20, fd, 4'd0)); end
    fd = first_diff(96, 96, 9'd30, 4'd1);
    total++;
    if (fd != -1) begin bad++; $display("[TB] FAIL ovl2_ev1 idx=%0d got=%h want=%h", fd, got_at(96 + fd), exp_word(9'd30, fd, 4'd1)); end
    total++;
    if (obs_e.size() != 2 || obs_e[1] !== {1'b1, 12'd2, 24'd2})
      begin bad++; $display("[TB] FAIL ovl2_evt n=%0d got=%h want=%h", obs_e.size(), (obs_e.size() > 1) ? obs_e[1] : 37'h0, {1'b1, 12'd2, 24'd2}); end
  endtask

  task automatic test_overlap3();
    int m, fd;
    bit ok;
    do_reset();
    SAMP_MAX = 7'd15;
    samp_pulses(120, 1);
    fire_match(1'b0, m);
    samp_pulses(5, 2);
    fire_match(1'b0, m);
    samp_pulses(5, 2);
    fire_match(1'b0, m);
    wait_words(288, 1200, ok);
    repeat (20) @(posedge WCLK);
    #1;
    total++;
    if (obs_w.size() != 288) begin bad++; $display("[TB] FAIL ovl3_count got=%0d want=288", obs_w.size()); end
    fd = first_diff(96, 96, 9'd25, 4'd1);
    total++;
    if (fd != -1) begin bad++; $display("[TB] FAIL ovl3_ev1 idx=%0d got=%h want=%h", fd, got_at(96 + fd), exp_word(9'd25, fd, 4'd1)); end
    fd = first_diff(192, 96, 9'd30, 4'd2);
    total++;
    if (fd != -1) begin bad++; $display("[TB] FAIL ovl3_ev2 idx=%0d got=%h want=%h", fd, got_at(192 + fd), exp_word(9'd30, fd, 4'd2)); end
  endtask

  task automatic test_overflow();
    int m, fd, nbad_e, nbad_w;
    bit ok;
    logic [36:0] want;
    do_reset();
    SAMP_MAX = 7'd15;
    samp_pulses(200, 1);
    EVT_BUF_AFL = 1'b1;
    for (int i = 0; i < 9; i++) fire_match(i[0], m);
    repeat (5) @(posedge WCLK);
    #1;
    total++;
    if (obs_e.size() != 8) begin bad++; $display("[TB] FAIL ovf_evt_count got=%0d want=8", obs_e.size()); end
    nbad_e = 0;
    for (int i = 0; i < 8 && i < obs_e.size(); i++) begin
      want = {i[0], 12'(i + 1), 24'(i + 1)};
      if (obs_e[i] !== want) nbad_e++;
    end
    total++;
    if (nbad_e != 0) begin bad++; $display("[TB] FAIL ovf_evt_data bad_records=%0d want=0", nbad_e); end
    total++;
    if (QOVF !== 1'b1) begin bad++; $display("[TB] FAIL ovf_qovf got=%b want=1", QOVF); end
    total++;
    if (obs_w.size() != 0) begin bad++; $display("[TB] FAIL ovf_words_while_afl got=%0d want=0", obs_w.size()); end
    EVT_BUF_AFL = 1'b0;
    wait_words(768, 3000, ok);
    repeat (20) @(posedge WCLK);
    #1;
    total++;
    if (obs_w.size() != 768) begin bad++; $display("[TB] FAIL ovf_count got=%0d want=768", obs_w.size()); end
    nbad_w = 0;
    for (int e = 0; e < 8; e++) begin
      fd = first_diff(96 * e, 96, 9'd100, 4'(e));
      if (fd != -1) nbad_w++;
    end
    total++;
    if (nbad_w != 0) begin bad++; $display("[TB] FAIL ovf_words bad_events=%0d want=0", nbad_w); end
    fire_match(1'b1, m);
    repeat (2) @(posedge WCLK);
    #1;
    total++;
    if (obs_e.size() != 9 || obs_e[8] !== {1'b1, 12'd10, 24'd10})
      begin bad++; $display("[TB] FAIL ovf_match_cnt n=%0d got=%h want=%h", obs_e.size(), (obs_e.size() > 8) ? obs_e[8] : 37'h0, {1'b1, 12'd10, 24'd10}); end
  endtask

  task automatic test_wrap();
    int m, fd;
    bit ok;
    do_reset();
    SAMP_MAX = 7'd15;
    samp_pulses(20, 1);
    total++;
    if (RING_WADDR !== 9'd20) begin bad++; $display("[TB] FAIL wrap_waddr got=%0d want=20", RING_WADDR); end
    fire_match(1'b0, m);
    wait_words(96, 400, ok);
    repeat (10) @(posedge WCLK);
    #1;
    fd = first_diff(0, 96, 9'd432, 4'd0);
    total++;
    if (fd != -1 || obs_w.size() != 96) begin bad++; $display("[TB] FAIL wrap_432 idx=%0d n=%0d got=%h want=%h", fd, obs_w.size(), got_at(fd), exp_word(9'd432, fd, 4'd0)); end
    do_reset();
    SAMP_MAX = 7'd7;
    samp_pulses(95, 1);
    fire_match(1'b0, m);
    wait_words(48, 300, ok);
    repeat (10) @(posedge WCLK);
    #1;
    fd = first_diff(0, 48, 9'd507, 4'd0);
    total++;
    if (fd != -1 || obs_w.size() != 48) begin bad++; $display("[TB] FAIL wrap_507 idx=%0d n=%0d got=%h want=%h", fd, obs_w.size(), got_at(fd), exp_word(9'd507, fd, 4'd0)); end
  endtask

  task automatic test_afl_pulse();
    int m, fd, k, nin;
    bit ok;
    do_reset();
    SAMP_MAX = 7'd15;
    samp_pulses(150, 1);
    fire_match(1'b0, m);
    wait_words(20, 200, ok);
    k = cyc;
    EVT_BUF_AFL = 1'b1;
    repeat (5) @(posedge WCLK);
    #1;
    EVT_BUF_AFL = 1'b0;
    wait_words(96, 400, ok);
    repeat (20) @(posedge WCLK);
    #1;
    nin = 0;
    foreach (obs_wc[i]) if (obs_wc[i] >= k + 5 && obs_wc[i] <= k + 7) nin++;
    total++;
    if (nin != 0) begin bad++; $display("[TB] FAIL afl_hold got=%0d want=0", nin); end
    total++;
    if (obs_w.size() != 96) begin bad++; $display("[TB] FAIL afl_count got=%0d want=96", obs_w.size()); end
    fd = first_diff(0, 96, 9'd50, 4'd0);
    total++;
    if (fd != -1) begin bad++; $display("[TB] FAIL afl_words idx=%0d got=%h want=%h", fd, got_at(fd), exp_word(9'd50, fd, 4'd0)); end
  endtask

  task automatic test_reset_mid_run();
    int m, n;
    bit ok;
    logic [77:0] outs;
    do_reset();
    SAMP_MAX = 7'd15;
    samp_pulses(150, 1);
    fire_match(1'b1, m);
    wait_words(20, 200, ok);
    RST_RESYNC = 1'b1;
    #1;
    outs = {RING_WE, RING_WADDR, RING_RADDR, WDATA, WREN, L1A_EVT_DATA, L1A_WRT_EN, BUSY, QOVF};
    total++;
    if (outs !== '0) begin bad++; $display("[TB] FAIL midrst_outputs got=%h want=0", outs); end
    n = obs_w.size();
    repeat (3) @(posedge WCLK);
    #1;
    total++;
    if (obs_w.size() != n) begin bad++; $display("[TB] FAIL midrst_wren got=%0d want=%0d", obs_w.size(), n); end
    RST_RESYNC = 1'b0;
    @(posedge WCLK);
    #1;
    clear_obs();
    fire_match(1'b0, m);
    repeat (2) @(posedge WCLK);
    #1;
    total++;
    if (obs_e.size() != 1 || obs_e[0] !== {1'b0, 12'd1, 24'd1})
      begin bad++; $display("[TB] FAIL midrst_counters n=%0d got=%h want=%h", obs_e.size(), (obs_e.size() > 0) ? obs_e[0] : 37'h0, {1'b0, 12'd1, 24'd1}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overlap2();
    test_overlap3();
    test_overflow();
    test_wrap();
    test_afl_pulse();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
